// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: round-robin maps execution-unit writeback requests
// onto NPORT registered register-file write ports, one cycle of latency.
module wb_port_arbiter #(
   parameter int NREQ  = 5,
   parameter int NPORT = 2,
   parameter int RB    = 2
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      flush,
   input  logic [NREQ-1:0]           req_vaild,
   input  logic [NREQ*(5+RB)-1:0]    req_rd0,
   input  logic [NREQ*64-1:0]        req_res,
   output logic [NREQ-1:0]           req_ready,
   output logic [NPORT-1:0]          wb_vaild_qout,
   output logic [NPORT*(5+RB)-1:0]   wb_rd0_qout,
   output logic [NPORT*64-1:0]       wb_res_qout,
   output logic [15:0]               conflict_cnt_qout
);

   localparam int TW = 5 + RB;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]        ptr;
   logic [PW-1:0]        last_idx;
   logic [PW-1:0]        ptr_nxt;
   logic [NREQ-1:0]      is_x0;
   logic [NREQ-1:0]      grant;
   logic [NPORT-1:0]     port_vld;
   logic [NPORT*TW-1:0]  port_rd0;
   logic [NPORT*64-1:0]  port_res;
   logic                 any_grant;
   logic                 refused;
   int                   n_grant;

   always_comb begin
      is_x0 = '0;
      for (int i = 0; i < NREQ; i++) begin
         is_x0[i] = (req_rd0[i*TW+RB +: 5] == 5'd0);
      end
   end

   // Walk requesters in rotated order starting at ptr; the k-th candidate
   // position maps to requester r when ptr+k wraps onto r.
   always_comb begin
      grant    = '0;
      port_vld = '0;
      port_rd0 = '0;
      port_res = '0;
      last_idx = ptr;
      n_grant  = 0;
      for (int k = 0; k < NREQ; k++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (((int'(ptr) + k == r) || (int'(ptr) + k == r + NREQ)) &&
                req_vaild[r] && !is_x0[r] && (n_grant < NPORT)) begin
               grant[r] = 1'b1;
               for (int p = 0; p < NPORT; p++) begin
                  if (p == n_grant) begin
                     port_vld[p]             = 1'b1;
                     port_rd0[p*TW +: TW]    = req_rd0[r*TW +: TW];
                     port_res[p*64 +: 64]    = req_res[r*64 +: 64];
                  end
               end
               last_idx = PW'(r);
               n_grant  = n_grant + 1;
            end
         end
      end
   end

   assign any_grant = |grant;
   assign refused   = |(req_vaild & ~is_x0 & ~grant);
   assign ptr_nxt   = (last_idx == PW'(NREQ-1)) ? '0 : last_idx + 1'b1;

   always_comb begin
      req_ready = '0;
      if (!RST && !flush) begin
         req_ready = req_vaild & (is_x0 | grant);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wb_vaild_qout     <= '0;
         wb_rd0_qout       <= '0;
         wb_res_qout       <= '0;
         ptr               <= '0;
         conflict_cnt_qout <= '0;
      end else if (flush) begin
         wb_vaild_qout <= '0;
      end else begin
         wb_vaild_qout <= port_vld;
         wb_rd0_qout   <= port_rd0;
         wb_res_qout   <= port_res;
         if (any_grant) begin
            ptr <= ptr_nxt;
         end
         if (refused && (conflict_cnt_qout != 16'hFFFF)) begin
            conflict_cnt_qout <= conflict_cnt_qout + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

   localparam int NREQ  = 5;
   localparam int NPORT = 2;
   localparam int RB    = 2;
   localparam int TW    = 5 + RB;

   logic                    CLK;
   logic                    RST;
   logic                    flush;
   logic [NREQ-1:0]         req_vaild;
   logic [NREQ*TW-1:0]      req_rd0;
   logic [NREQ*64-1:0]      req_res;
   logic [NREQ-1:0]         req_ready;
   logic [NPORT-1:0]        wb_vaild_qout;
   logic [NPORT*TW-1:0]     wb_rd0_qout;
   logic [NPORT*64-1:0]     wb_res_qout;
   logic [15:0]             conflict_cnt_qout;

   int n_vec;
   int n_err;

   wb_port_arbiter #(.NREQ(NREQ), .NPORT(NPORT), .RB(RB)) dut (
      .CLK               (CLK),
      .RST               (RST),
      .flush             (flush),
      .req_vaild         (req_vaild),
      .req_rd0           (req_rd0),
      .req_res           (req_res),
      .req_ready         (req_ready),
      .wb_vaild_qout     (wb_vaild_qout),
      .wb_rd0_qout       (wb_rd0_qout),
      .wb_res_qout       (wb_res_qout),
      .conflict_cnt_qout (conflict_cnt_qout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_req();
      req_vaild = '0;
      req_rd0   = '0;
      req_res   = '0;
      flush     = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [TW-1:0] tag, input logic [63:0] res);
      req_vaild[i]        = 1'b1;
      req_rd0[i*TW +: TW] = tag;
      req_res[i*64 +: 64] = res;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      clear_req();
      #2;
      RST = 1'b0;
   endtask

   function automatic logic [TW-1:0] tag_of(input int i);
      return TW'((i + 1) << RB);
   endfunction

   function automatic logic [63:0] res_of(input int i);
      return 64'h100 + 64'(i);
   endfunction

   logic [4:0] exp_ready [3] = '{5'b00011, 5'b01100, 5'b10001};
   int         exp_p0    [3] = '{0, 2, 4};
   int         exp_p1    [3] = '{1, 3, 0};

   initial begin
      n_vec = 0;
      n_err = 0;
      RST   = 1'b1;
      clear_req();
      set_req(0, 7'h00, 64'h1);
      #1;
      check("rst_ready",  64'(req_ready), 64'h0);
      check("rst_vaild",  64'(wb_vaild_qout), 64'h0);
      check("rst_cnt",    64'(conflict_cnt_qout), 64'h0);

      // single alu request
      do_reset();
      set_req(0, {5'd3, 2'd1}, 64'hA5);
      #1;
      check("alu_ready", 64'(req_ready), 64'h01);
      tick();
      clear_req();
      check("alu_vaild", 64'(wb_vaild_qout), 64'h1);
      check("alu_rd0",   64'(wb_rd0_qout[0 +: TW]), 64'h0D);
      check("alu_res",   wb_res_qout[0 +: 64], 64'hA5);

      // all five held valid: rotating pairs
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, tag_of(i), res_of(i));
      for (int c = 0; c < 3; c++) begin
         #1;
         check("rr_ready", 64'(req_ready), 64'(exp_ready[c]));
         tick();
         check("rr_vaild", 64'(wb_vaild_qout), 64'h3);
         check("rr_p0_rd0", 64'(wb_rd0_qout[0 +: TW]), 64'(tag_of(exp_p0[c])));
         check("rr_p1_rd0", 64'(wb_rd0_qout[TW +: TW]), 64'(tag_of(exp_p1[c])));
         check("rr_p1_res", wb_res_qout[64 +: 64], res_of(exp_p1[c]));
      end
      check("rr_cnt", 64'(conflict_cnt_qout), 64'd3);

      // x0 request accepted without a port
      do_reset();
      set_req(2, {5'd0, 2'd3}, 64'hDEAD);
      set_req(4, {5'd7, 2'd2}, 64'hBEEF);
      #1;
      check("x0_ready", 64'(req_ready), 64'h14);
      tick();
      clear_req();
      check("x0_vaild", 64'(wb_vaild_qout), 64'h1);
      check("x0_rd0",   64'(wb_rd0_qout[0 +: TW]), 64'h1E);
      check("x0_res",   wb_res_qout[0 +: 64], 64'hBEEF);
      check("x0_cnt",   64'(conflict_cnt_qout), 64'd0);

      // flush with both ports registered
      do_reset();
      for (int i = 0; i < 3; i++) set_req(i, tag_of(i), res_of(i));
      #1;
      check("fl_pre_ready", 64'(req_ready), 64'h03);
      tick();
      check("fl_pre_vaild", 64'(wb_vaild_qout), 64'h3);
      flush = 1'b1;
      #1;
      check("fl_ready", 64'(req_ready), 64'h00);
      tick();
      check("fl_vaild", 64'(wb_vaild_qout), 64'h0);
      check("fl_cnt",   64'(conflict_cnt_qout), 64'd1);
      flush = 1'b0;
      #1;
      check("fl_ptr_ready", 64'(req_ready), 64'h05);
      tick();
      check("fl_post_p0", 64'(wb_rd0_qout[0 +: TW]), 64'(tag_of(2)));
      check("fl_post_p1", 64'(wb_rd0_qout[TW +: TW]), 64'(tag_of(0)));
      check("fl_post_cnt", 64'(conflict_cnt_qout), 64'd2);

      // asynchronous reset while ports are valid
      clear_req();
      #2;
      RST = 1'b1;
      #1;
      check("ar_vaild", 64'(wb_vaild_qout), 64'h0);
      check("ar_rd0",   64'(wb_rd0_qout), 64'h0);
      check("ar_res",   wb_res_qout[63:0] | wb_res_qout[127:64], 64'h0);
      check("ar_cnt",   64'(conflict_cnt_qout), 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      tick();
      check("ar_no_stale", 64'(wb_vaild_qout), 64'h0);
      for (int i = 0; i < 3; i++) set_req(i, tag_of(i), res_of(i));
      #1;
      check("ar_ptr_ready", 64'(req_ready), 64'h03);
      tick();

      // conflict counter saturation
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, tag_of(i), res_of(i));
      for (int c = 0; c < 65534; c++) tick();
      check("sat_pre", 64'(conflict_cnt_qout), 64'hFFFE);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("sat_hold", 64'(conflict_cnt_qout), 64'hFFFF);
      end
      clear_req();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 5, meaning number of execution-unit requesters: 0=alu, 1=bru, 2=lsu, 3=csr, 4=mul.
REQ-002 SHALL have parameter NPORT, default 2, meaning number of physical-register-file write ports.
REQ-003 SHALL have parameter RB, default 2, meaning rename-index bits; tag width TW=5+RB, tag={arch reg[4:0], rename idx[RB-1:0]}.
REQ-004 SHALL have port CLK, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit: commit abort; discards in-flight and registered writebacks.
REQ-007 SHALL have port req_vaild, input, NREQ bits: per-requester writeback request.
REQ-008 SHALL have port req_rd0, input, NREQ*TW bits: packed destination tags; requester i uses slice [i*TW +: TW].
REQ-009 SHALL have port req_res, input, NREQ*64 bits: packed results; requester i uses slice [i*64 +: 64].
REQ-010 SHALL have port req_ready, output, NREQ bits: combinational accept, same cycle.
REQ-011 SHALL have port wb_vaild_qout, output, NPORT bits: registered write-port enables.
REQ-012 SHALL have port wb_rd0_qout, output, NPORT*TW bits: registered write-port tags.
REQ-013 SHALL have port wb_res_qout, output, NPORT*64 bits: registered write-port data.
REQ-014 SHALL have port conflict_cnt_qout, output, 16 bits: saturating count of cycles in which at least one valid request was refused.

Function
REQ-015 SHALL treat a request as transferred when req_vaild[i] and req_ready[i] are both 1 in the same cycle.
REQ-016 SHALL require each requester to hold vaild, rd0 and res stable until transferred; the arbiter SHALL NOT rely on the requester dropping a request.
REQ-017 SHALL accept (ready=1) any valid request whose arch reg field is 0 (x0 tag), without consuming a port and without producing a write.
REQ-018 SHALL keep a round-robin pointer ptr, range 0..NREQ-1.
REQ-019 SHALL scan non-x0 valid requesters in order ptr, ptr+1, ... mod NREQ and grant the first NPORT found.
REQ-020 SHALL assign grants to ports in scan order: first grant to port 0, second to port 1.
REQ-021 SHALL, on the cycle after grant, drive each granted port's wb_vaild_qout=1 with its tag and data; latency is exactly 1 cycle.
REQ-022 SHALL drive wb_vaild_qout=0 on unused ports; their rd0/res values are don't-care.
REQ-023 SHALL, when at least one port was granted, set ptr to (index of last granted requester + 1) mod NREQ.
REQ-024 SHALL leave ptr unchanged when no port was granted.
REQ-025 SHALL bound starvation: a continuously valid requester is granted within ceil(NREQ/NPORT) cycles.
REQ-026 SHALL, in any cycle flush=1, force req_ready=0 for all requesters, including x0 requests.
REQ-027 SHALL, in any cycle flush=1, clear all wb_vaild_qout at the next edge.
REQ-028 SHALL NOT change ptr in any cycle flush=1.
REQ-029 SHALL NOT increment conflict_cnt in any cycle flush=1.
REQ-030 SHALL increment conflict_cnt by 1 per cycle when a valid non-x0 request is not granted and flush=0, saturating at 0xFFFF.
REQ-031 SHALL never issue two ports with the same requester in one cycle; duplicate-tag detection is the requesters' responsibility.

Reset
REQ-032 SHALL, while RST=1 (asynchronously): wb_vaild_qout=0, wb_rd0_qout=0, wb_res_qout=0, ptr=0, conflict_cnt_qout=0.
REQ-033 SHALL hold req_ready=0 while RST=1.
REQ-034 SHALL, if reset is asserted mid-operation, drop pending registered writes and SHALL NOT emit them after release.
REQ-035 SHALL accept requests normally from the first edge after RST deasserts.

Verification
REQ-036 SHALL pass: ptr=0; only alu valid, tag {5'd3,2'd1}, res 0xA5 -> req_ready=00001 same cycle; next cycle port0 vaild, rd0=0x0D, res=0xA5; port1 idle.
REQ-037 SHALL pass: all 5 valid, held every cycle, from ptr=0 -> grants {0,1}, then {2,3}, then {4,0}; conflict_cnt=3 after three cycles.
REQ-038 SHALL pass: lsu valid with x0 tag, plus mul valid -> both ready; next cycle only port0 vaild, carrying mul data.
REQ-039 SHALL pass: flush=1 with 3 valid requests and 2 ports registered -> req_ready=0, next cycle wb_vaild_qout=00, ptr unchanged.
REQ-040 SHALL pass: conflict_cnt preloaded to 0xFFFE, then 3 conflict cycles -> counter reads 0xFFFF and stays there.
REQ-041 SHALL pass: RST pulsed while port outputs are valid -> outputs immediately 0, without a clock edge; ptr=0.
